// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder and the CPU that boots from it.
// START_PC is the address the boot loader writes first and the address the
// CPU fetches first after busy drops; both sides take it from here.
package memory_responder_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int unsigned START_PC = 8;

endpackage

// File: rtl/memory_responder_sp_ram.sv
// sp_ram: single-port word array with a registered, write-first read port.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (read register only)
//   we     write enable for word[addr]
//   rd_en  when low the read register loads 0 instead of array data
//   addr   word address
//   wdata  write data
//   rdata  registered read data, one cycle after addr
module sp_ram #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  // Array has no reset; the owner clears it explicitly.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Write-first: a read of the word being written returns the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (!rd_en) begin
      rdata <= '0;
    end else begin
      rdata <= we ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// memory_responder: CPU data/program memory with a boot engine.
// After reset the whole array is zeroed (CLEAR), then an optional program
// image is accepted over a valid/ready port starting at LOAD_BASE (LOAD).
// busy stays high until READY and is meant to hold the CPU in reset.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   we, addr, data    CPU write enable, word address, write data
//   out               CPU read data, one cycle after addr (0 while busy)
//   ld_valid/ld_data  loader word and its valid
//   ld_last           marks the final loader word
//   ld_ready          memory accepts a loader word this cycle
//   busy              high while clearing or loading (registered)
//   ld_count          number of words loaded in the last boot
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned LOAD_BASE   = START_PC,
  parameter int unsigned LOAD_ENABLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   ld_count
);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] cptr, cptr_n;
  logic [ADDR_WIDTH-1:0] lptr, lptr_n;
  logic [ADDR_WIDTH:0]   ld_count_n;
  logic                  busy_n;

  logic                  ram_we;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      cptr     <= '0;
      lptr     <= ADDR_WIDTH'(LOAD_BASE);
      ld_count <= '0;
      busy     <= 1'b1;
    end else begin
      state    <= state_n;
      cptr     <= cptr_n;
      lptr     <= lptr_n;
      ld_count <= ld_count_n;
      busy     <= busy_n;
    end
  end

  // One write port: clear engine, loader or CPU, selected by state.
  always_comb begin
    state_n    = state;
    cptr_n     = cptr;
    lptr_n     = lptr;
    ld_count_n = ld_count;
    ld_ready   = 1'b0;
    ram_we     = 1'b0;
    ram_rd_en  = 1'b0;
    ram_addr   = addr;
    ram_wdata  = data;

    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = cptr;
        ram_wdata = '0;
        cptr_n    = cptr + ADDR_WIDTH'(1);
        lptr_n    = ADDR_WIDTH'(LOAD_BASE);
        if (cptr == '1) begin
          state_n = (LOAD_ENABLE != 0) ? LOAD : READY;
        end
      end
      LOAD: begin
        ld_ready  = 1'b1;
        ram_addr  = lptr;
        ram_wdata = ld_data;
        if (ld_valid) begin
          ram_we     = 1'b1;
          lptr_n     = lptr + ADDR_WIDTH'(1);
          ld_count_n = ld_count + (ADDR_WIDTH + 1)'(1);
          // Top word ends the load: the pointer never wraps back to 0.
          if (ld_last || (lptr == '1)) begin
            state_n = READY;
          end
        end
      end
      READY: begin
        ram_we    = we;
        ram_rd_en = 1'b1;
      end
      default: begin
        state_n = CLEAR;
      end
    endcase

    // busy is registered off the next state so it drops with the READY entry.
    busy_n = (state_n != READY);
  end

  sp_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .rd_en(ram_rd_en),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(out)
  );

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: one instance with the load phase, one without.
// Read expectations go into a scoreboard queue; a monitor pops one per read
// result. Status checks are queued and compared at the next falling edge.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [5:0]  addr;
  logic [15:0] data;
  logic [15:0] out, out0;
  logic        ld_valid, ld_last;
  logic [15:0] ld_data;
  logic        ld_ready, ld_ready0;
  logic        busy, busy0;
  logic [6:0]  ld_count, ld_count0;

  always #5 clk = ~clk;

  memory_responder #(
    .ADDR_WIDTH(6), .DATA_WIDTH(16), .LOAD_BASE(8), .LOAD_ENABLE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data(data), .out(out),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .busy(busy), .ld_count(ld_count)
  );

  memory_responder #(
    .ADDR_WIDTH(6), .DATA_WIDTH(16), .LOAD_BASE(8), .LOAD_ENABLE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data(data), .out(out0),
    .ld_valid(1'b0), .ld_data(16'h0000), .ld_last(1'b0),
    .ld_ready(ld_ready0), .busy(busy0), .ld_count(ld_count0)
  );

  typedef struct {
    int    which;
    int    exp;
    string name;
  } rd_t;

  typedef struct {
    int    sig;
    int    exp;
    string name;
  } chk_t;

  rd_t  rd_q[$];
  chk_t imm_q[$];
  logic rd_req = 1'b0;
  logic rd_pend = 1'b0;
  logic done = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int sig, input int exp, input string name);
    chk_t c;
    c.sig = sig; c.exp = exp; c.name = name;
    imm_q.push_back(c);
  endtask

  // Present addr (optionally with a write) and queue the value out must show.
  task automatic access(input int which, input int a, input logic w,
                        input int d, input int exp, input string name);
    rd_t r;
    r.which = which; r.exp = exp; r.name = name;
    addr = 6'(a); we = w; data = 16'(d); rd_req = 1'b1;
    rd_q.push_back(r);
    tick();
    rd_req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input int which, input int a, input int exp, input string name);
    access(which, a, 1'b0, 0, exp, name);
  endtask

  // Read latency tracked by the bench: a request seen at an edge has its
  // result on out for the rest of that cycle.
  initial forever begin
    @(posedge clk);
    rd_pend = rd_req;
  end

  initial forever begin
    @(negedge clk);
    if (rd_pend) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_underflow: got read result with no expectation queued");
      end else begin
        rd_t r;
        int  act;
        r = rd_q.pop_front();
        act = (r.which != 0) ? int'(out0) : int'(out);
        if (act != r.exp) begin
          bad++;
          $display("FAIL %s: got %0h want %0h", r.name, act, r.exp);
        end
      end
    end
    while (imm_q.size() > 0) begin
      chk_t c;
      int   act;
      c = imm_q.pop_front();
      case (c.sig)
        0: act = int'(out);
        1: act = int'(busy);
        2: act = int'(ld_count);
        3: act = int'(ld_ready);
        4: act = int'(out0);
        5: act = int'(busy0);
        6: act = int'(ld_ready0);
        default: act = int'(ld_count0);
      endcase
      total++;
      if (act != c.exp) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", c.name, act, c.exp);
      end
    end
    if (done) begin
      total++;
      if (rd_q.size() != 0) begin
        bad++;
        $display("FAIL rd_leftover: got %0d pending want 0", rd_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] img [0:2];
    img[0] = 16'h7100; img[1] = 16'h8100; img[2] = 16'hF000;

    rst_n = 1'b0; we = 1'b0; addr = '0; data = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    tick(); tick();
    expect_now(0, 0, "rst_out");
    expect_now(1, 1, "rst_busy");
    expect_now(2, 0, "rst_count");
    expect_now(3, 0, "rst_ldready");

    // CPU write attempted during the whole CLEAR must be dropped.
    we = 1'b1; addr = 6'd20; data = 16'h1234;
    rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      expect_now(5, (i < 64) ? 1 : 0, "clear_busy0");
      if (i == 10) expect_now(0, 0, "clear_out");
    end
    we = 1'b0;
    expect_now(1, 1, "load_busy");
    expect_now(3, 1, "load_ldready");
    expect_now(6, 0, "le0_ldready");
    expect_now(7, 0, "le0_count");

    for (int a = 0; a < 64; a++) rd(1, a, 0, "le0_zero");

    // Gapped three-word image.
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b0; ld_last = 1'b0;
      expect_now(2, k, "count_progress");
      tick();
      ld_valid = 1'b1; ld_data = img[k]; ld_last = (k == 2);
      if (k == 2) expect_now(1, 1, "busy_before_last");
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    expect_now(1, 0, "busy_after_last");
    expect_now(2, 3, "count3");
    expect_now(3, 0, "ldready_off");
    rd(0, 8,  16'h7100, "img8");
    rd(0, 9,  16'h8100, "img9");
    rd(0, 10, 16'hF000, "img10");
    rd(0, 11, 0, "img11");
    rd(0, 20, 0, "clear_we20");

    // Write-first then plain read of the same word.
    access(0, 5, 1'b1, 16'hBEEF, 16'hBEEF, "wf_write");
    rd(0, 5, 16'hBEEF, "wf_read");
    tick();

    // Asynchronous reset while READY with out nonzero.
    #2 rst_n = 1'b0;
    expect_now(0, 0, "rdy_rst_out");
    expect_now(1, 1, "rdy_rst_busy");
    expect_now(2, 0, "rdy_rst_count");
    tick();
    rst_n = 1'b1;
    repeat (64) tick();

    // Two words in, then reset mid-LOAD.
    ld_valid = 1'b1; ld_data = 16'hAAAA; tick();
    ld_data = 16'hBBBB; tick();
    ld_valid = 1'b0;
    expect_now(2, 2, "mid_count2");
    tick();
    #2 rst_n = 1'b0;
    expect_now(0, 0, "midrst_out");
    expect_now(1, 1, "midrst_busy");
    expect_now(2, 0, "midrst_count");
    tick();
    rst_n = 1'b1;
    repeat (64) tick();
    expect_now(1, 1, "reclear_busy");
    ld_valid = 1'b1; ld_data = 16'h0000; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    expect_now(1, 0, "reload_busy");
    expect_now(2, 1, "reload_count");
    rd(0, 8, 0, "reload8");
    rd(0, 9, 0, "reload9");

    // Loader never raises ld_last: fills 8..63, 57th word refused.
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    repeat (64) tick();
    for (int i = 0; i < 57; i++) begin
      ld_valid = 1'b1; ld_data = 16'(32'h1000 + i);
      tick();
    end
    ld_valid = 1'b0;
    expect_now(2, 56, "full_count");
    expect_now(3, 0, "full_ldready");
    expect_now(1, 0, "full_busy");
    rd(0, 8,  16'h1000, "full8");
    rd(0, 40, 16'h1020, "full40");
    rd(0, 63, 16'h1037, "full63");
    rd(0, 7,  0, "full7");
    rd(0, 0,  0, "full0");

    tick();
    done = 1'b1;
  end

endmodule
